// File: rtl/quad_decoder_if.sv
// Quadrature decoder bundle: encoder inputs and controls in, step/dir/err/state out.
// master drives a_in, b_in, en, clr_err; slave (the decoder) drives the results.
interface quad_decoder_if;
  logic       a_in;
  logic       b_in;
  logic       en;
  logic       clr_err;
  logic       step;
  logic       dir;
  logic       err;
  logic [3:0] err_cnt;
  logic [1:0] state;

  modport master (
    output a_in, b_in, en, clr_err,
    input  step, dir, err, err_cnt, state
  );

  modport slave (
    input  a_in, b_in, en, clr_err,
    output step, dir, err, err_cnt, state
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, per-channel glitch filter, step/dir/err gen.
// Ports: clk, rst_n (async, active-low), bus (slave modport of quad_decoder_if).
module quad_decoder #(
  parameter int FILT_LEN = 3
) (
  input logic       clk,
  input logic       rst_n,
  quad_decoder_if.slave bus
);

  localparam int        PRIME_LEN = FILT_LEN + 2;
  localparam logic [3:0] FMAX = 4'(FILT_LEN - 1);
  localparam logic [4:0] PMAX = 5'(PRIME_LEN - 1);

  typedef enum logic {
    PRIME,
    RUN
  } phase_t;

  phase_t     phase;
  phase_t     phase_nxt;
  logic [4:0] pcnt;
  logic       priming;

  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [3:0] fcnt [2];

  logic [1:0] cur;
  logic       step_q;
  logic       dir_q;
  logic       err_q;
  logic [3:0] cnt_q;

  logic [1:0] dp;
  logic       mv_up;
  logic       mv_dn;
  logic       mv_bad;

  // Position along the up sequence 00->10->11->01
  function automatic logic [1:0] pos(input logic [1:0] ab);
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
  endfunction

  assign raw = {bus.a_in, bus.b_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PRIME;
      pcnt  <= 5'd0;
    end else begin
      phase <= phase_nxt;
      if (priming) pcnt <= pcnt + 5'd1;
    end
  end

  always_comb begin
    phase_nxt = phase;
    priming   = (phase == PRIME);
    if (priming && pcnt == PMAX) phase_nxt = RUN;
  end

  // While priming, filt and state follow the synchronizer directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt    <= 2'b00;
      fcnt[0] <= 4'd0;
      fcnt[1] <= 4'd0;
    end else if (priming) begin
      filt    <= sync2;
      fcnt[0] <= 4'd0;
      fcnt[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 4'd0;
        end else if (fcnt[i] == FMAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 4'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    dp     = pos(filt) - pos(cur);
    mv_up  = 1'b0;
    mv_dn  = 1'b0;
    mv_bad = 1'b0;
    unique case (1'b1)
      (dp == 2'd1): mv_up  = 1'b1;
      (dp == 2'd3): mv_dn  = 1'b1;
      (dp == 2'd2): mv_bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= 2'b00;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else if (priming) begin
      cur    <= sync2;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cur    <= filt;
      step_q <= bus.en & (mv_up | mv_dn);
      err_q  <= bus.en & mv_bad;
      if (bus.en && (mv_up || mv_dn)) dir_q <= mv_up;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (bus.clr_err) begin
      cnt_q <= 4'd0;
    end else if (!priming && bus.en && mv_bad && cnt_q != 4'hF) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;
  assign bus.state   = cur;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed vectors, behavioural model, literal checks.
// Prints one summary line with check and error counts.
module tb_quad_decoder;

  localparam int F = 3;

  logic clk;
  logic rst_n;

  quad_decoder_if bus ();

  quad_decoder #(.FILT_LEN(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nstep = 0;
  int nerr = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_d1, m_d2, m_filt, m_state;
  logic       m_step, m_err, m_dir;
  logic [3:0] m_cnt;
  int         m_prime;
  logic [1:0] hv[$];
  logic [1:0] s2, of, os, nf, dl;
  bit         ok;

  function automatic logic [1:0] pos_m(input logic [1:0] ab);
    if (ab == 2'b00) return 2'd0;
    if (ab == 2'b10) return 2'd1;
    if (ab == 2'b11) return 2'd2;
    return 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = 0; m_d2 = 0; m_filt = 0; m_state = 0;
      m_step = 0; m_err = 0; m_dir = 0; m_cnt = 0;
      m_prime = F + 2;
      hv.delete();
    end else begin
      s2 = m_d2;
      of = m_filt;
      os = m_state;
      if (m_prime > 0) begin
        m_filt = s2;
        m_state = s2;
        m_step = 0;
        m_err = 0;
        m_prime--;
        hv.delete();
      end else begin
        hv.push_back(s2);
        if (hv.size() > F) void'(hv.pop_front());
        nf = of;
        for (int c = 0; c < 2; c++) begin
          ok = (hv.size() == F);
          for (int i = 0; i < hv.size(); i++)
            if (hv[i][c] == of[c]) ok = 0;
          if (ok) nf[c] = ~of[c];
        end
        m_state = of;
        m_filt = nf;
        dl = pos_m(of) - pos_m(os);
        m_step = bus.en && (dl == 2'd1 || dl == 2'd3);
        m_err = bus.en && (dl == 2'd2);
        if (m_step) m_dir = (dl == 2'd1);
        if (m_err && m_cnt != 4'hF) m_cnt++;
      end
      if (bus.clr_err) m_cnt = 0;
      m_d2 = m_d1;
      m_d1 = {bus.a_in, bus.b_in};
    end
  end

  logic [8:0] act_v, exp_v;

  always @(negedge clk) begin
    act_v = {bus.step, bus.err, bus.dir, bus.err_cnt, bus.state};
    exp_v = {m_step, m_err, m_dir, m_cnt, m_state};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp actual=%b required=%b t=%0t", act_v, exp_v, $time);
    end
    if (bus.step) nstep++;
    if (bus.err) nerr++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    bus.a_in = v[1];
    bus.b_in = v[0];
  endtask

  task automatic wait_pulse(input string nm, input int lat, input bit want_err);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.step || bus.err) found = 1;
    end
    check({nm, "_lat"}, n, lat);
    check({nm, "_kind"}, {bus.step, bus.err}, want_err ? 1 : 2);
  endtask

  logic [1:0] upv [4];
  logic [1:0] dnv [4];
  int s0, e0;

  initial begin
    upv[0] = 2'b10; upv[1] = 2'b11; upv[2] = 2'b01; upv[3] = 2'b00;
    dnv[0] = 2'b01; dnv[1] = 2'b11; dnv[2] = 2'b10; dnv[3] = 2'b00;
    rst_n = 0;
    bus.a_in = 0; bus.b_in = 0;
    bus.en = 1; bus.clr_err = 0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {bus.step, bus.err, bus.dir, bus.err_cnt, bus.state}, 0);
    rst_n = 1;
    repeat (10) @(negedge clk);

    s0 = nstep;
    for (int i = 0; i < 4; i++) begin
      drive(upv[i]);
      wait_pulse("up", 6, 0);
      check("up_dir", bus.dir, 1);
      repeat (4) @(negedge clk);
    end
    check("up_steps", nstep - s0, 4);
    check("up_state", bus.state, 0);
    check("up_errcnt", bus.err_cnt, 0);

    s0 = nstep;
    for (int i = 0; i < 4; i++) begin
      drive(dnv[i]);
      wait_pulse("dn", 6, 0);
      check("dn_dir", bus.dir, 0);
      repeat (4) @(negedge clk);
    end
    check("dn_steps", nstep - s0, 4);
    check("dn_state", bus.state, 0);

    s0 = nstep; e0 = nerr;
    drive(2'b10);
    @(negedge clk);
    drive(2'b00);
    repeat (12) @(negedge clk);
    check("glitch_step", nstep - s0, 0);
    check("glitch_err", nerr - e0, 0);
    check("glitch_state", bus.state, 0);

    drive(2'b11);
    wait_pulse("jump", 6, 1);
    check("jump_cnt", bus.err_cnt, 1);
    check("jump_state", bus.state, 3);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      drive((i % 2 == 0) ? 2'b00 : 2'b11);
      wait_pulse("alt", 6, 1);
      repeat (4) @(negedge clk);
    end
    check("sat_cnt", bus.err_cnt, 15);

    drive(2'b00);
    repeat (5) @(negedge clk);
    bus.clr_err = 1;
    @(posedge clk);
    #1;
    check("race_err", bus.err, 1);
    @(negedge clk);
    bus.clr_err = 0;
    check("race_cnt", bus.err_cnt, 0);
    repeat (5) @(negedge clk);

    drive(2'b11);
    wait_pulse("jump2", 6, 1);
    check("jump2_cnt", bus.err_cnt, 1);
    @(negedge clk);
    bus.clr_err = 1;
    @(negedge clk);
    bus.clr_err = 0;
    check("clr_cnt", bus.err_cnt, 0);
    repeat (4) @(negedge clk);

    drive(2'b00);
    repeat (10) @(negedge clk);
    check("pre_en_cnt", bus.err_cnt, 1);
    bus.en = 0;
    s0 = nstep; e0 = nerr;
    drive(2'b10);
    repeat (10) @(negedge clk);
    drive(2'b11);
    repeat (10) @(negedge clk);
    check("en0_step", nstep - s0, 0);
    check("en0_err", nerr - e0, 0);
    check("en0_state", bus.state, 3);
    check("en0_cnt", bus.err_cnt, 1);
    check("en0_dir", bus.dir, 0);
    bus.en = 1;
    drive(2'b01);
    wait_pulse("en1", 6, 0);
    check("en1_dir", bus.dir, 1);
    repeat (4) @(negedge clk);

    drive(2'b11);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_outs",
          {bus.step, bus.err, bus.dir, bus.err_cnt, bus.state}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    s0 = nstep; e0 = nerr;
    repeat (12) @(negedge clk);
    check("rel_state", bus.state, 3);
    check("rel_cnt", bus.err_cnt, 0);
    check("rel_err", nerr - e0, 0);
    check("rel_step", nstep - s0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
